rep_pixel_ctrl: RTL

- Sequencer for the pixel-replication scaler.
- Walks every destination pixel of a DST_W x DST_H frame in raster order, computes the replicated source address, reads source memory, and writes the destination frame buffer.
- Sits between the source image memory (synchronous read, 1-cycle latency) and the output frame memory later dumped to saida.mem.
- Throughput is 1 pixel/cycle, under a start/busy/done handshake.

---
 rtl/rep_pixel_ctrl_pkg.sv | 35 +++
 rtl/rep_addr_gen.sv | 70 +++++++
 rtl/rep_pixel_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/rep_pixel_ctrl_pkg.sv
// Shared definitions for the pixel-replication scaler sequencer: zoom codes,
// FSM states and default frame geometry.
package rep_pixel_ctrl_pkg;

  localparam int unsigned DEF_DST_W  = 320;
  localparam int unsigned DEF_DST_H  = 240;
  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned DEF_ADDR_W = 17;

  localparam logic [1:0] Z1X  = 2'b00;
  localparam logic [1:0] Z2X  = 2'b01;
  localparam logic [1:0] Z4X  = 2'b10;
  localparam logic [1:0] ZILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Mask of the low shift bits of y; a source row starts when they are all zero.
  function automatic logic [1:0] low_mask(input logic [1:0] s);
    logic [1:0] m;
    m = 2'b00;
    case (s)
      Z1X:     m = 2'b00;
      Z2X:     m = 2'b01;
      Z4X:     m = 2'b11;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rep_addr_gen.sv
// Raster walker for the replication scaler: x/y counters, source row base,
// destination index and last-pixel flag. Source address built without a multiplier.
module rep_addr_gen
  import rep_pixel_ctrl_pkg::*;
#(
  parameter int unsigned DST_W  = DEF_DST_W,
  parameter int unsigned DST_H  = DEF_DST_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        shift,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_idx,
  output logic              last
);

  localparam int unsigned X_W = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int unsigned Y_W = (DST_H > 1) ? $clog2(DST_H) : 1;

  logic [X_W-1:0]    x, x_n;
  logic [Y_W-1:0]    y, y_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [ADDR_W-1:0] dst_idx_n, src_addr_n, sw;
  logic              last_n;

  // Next raster position; the counters park on the final pixel so src_addr holds.
  always_comb begin
    x_n        = x;
    y_n        = y;
    row_base_n = row_base;
    dst_idx_n  = dst_idx;
    sw         = ADDR_W'(DST_W) >> shift;
    if (advance && !last) begin
      dst_idx_n = dst_idx + ADDR_W'(1);
      if (x == X_W'(DST_W - 1)) begin
        x_n = '0;
        y_n = y + Y_W'(1);
        if ((y_n & Y_W'(low_mask(shift))) == '0) begin
          row_base_n = row_base + sw;
        end
      end else begin
        x_n = x + X_W'(1);
      end
    end
    src_addr_n = row_base_n + ADDR_W'(x_n >> shift);
    last_n     = (x_n == X_W'(DST_W - 1)) && (y_n == Y_W'(DST_H - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      dst_idx  <= '0;
      src_addr <= '0;
      last     <= 1'b0;
    end else begin
      x        <= x_n;
      y        <= y_n;
      row_base <= row_base_n;
      dst_idx  <= dst_idx_n;
      src_addr <= src_addr_n;
      last     <= last_n;
    end
  end

endmodule

// File: rtl/rep_pixel_ctrl.sv
// Pixel-replication scaler sequencer: start/busy/done control FSM and the
// one-stage write pipeline from source read port to destination frame buffer.
module rep_pixel_ctrl
  import rep_pixel_ctrl_pkg::*;
#(
  parameter int unsigned DST_W  = DEF_DST_W,
  parameter int unsigned DST_H  = DEF_DST_H,
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        factor,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_we
);

  state_e            state;
  logic [1:0]        shift;
  logic [ADDR_W-1:0] dst_idx;
  logic              gen_last;
  logic              gen_clear_c;
  logic              gen_adv_c;

  assign gen_clear_c = (state == ST_IDLE) && start && (factor != ZILL);
  assign gen_adv_c   = (state == ST_RUN) && !abort;

  rep_addr_gen #(
    .DST_W  (DST_W),
    .DST_H  (DST_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (gen_clear_c),
    .advance  (gen_adv_c),
    .shift    (shift),
    .src_addr (src_addr),
    .dst_idx  (dst_idx),
    .last     (gen_last)
  );

  // Read data arrives the cycle the write is presented, so it passes straight
  // through, gated to zero whenever no write is in flight.
  assign dst_data = dst_we ? src_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift    <= Z1X;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      dst_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (factor == ZILL) begin
              err <= 1'b1;
            end else begin
              shift <= factor;
              busy  <= 1'b1;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            dst_we   <= 1'b1;
            dst_addr <= dst_idx;
            if (gen_last) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          busy <= 1'b0;
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
